// File: rtl/ps2_rx_fifo_if.sv
// Consumer-side bundle of the PS/2 receiver: FIFO head, pop strobe and error flags.
// The receiver connects through the slave modport, the consuming logic through master.
interface ps2_rx_fifo_if #(
    parameter int CODE_BYTES = 4
);
    logic                    rd_en;
    logic [8*CODE_BYTES-1:0] code_out;
    logic [3:0]              code_len;
    logic                    empty;
    logic                    full;
    logic                    parity_err;
    logic                    frame_err;
    logic                    overflow;

    modport slave (
        input  rd_en,
        output code_out, code_len, empty, full, parity_err, frame_err, overflow
    );

    modport master (
        output rd_en,
        input  code_out, code_len, empty, full, parity_err, frame_err, overflow
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: oversampled framing, multi-byte scan-code assembly
// and a show-ahead FIFO of completed codes.
module ps2_rx_fifo #(
    parameter int CODE_BYTES     = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_clock,
    input  logic          key_data,
    ps2_rx_fifo_if.slave  bus
);
    localparam int BW = 8 * CODE_BYTES;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LB = (CODE_BYTES < 3) ? CODE_BYTES : 3;
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]  TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]     MAX_LEN  = 4'(CODE_BYTES);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    // synchronisers and edge detection
    logic [SYNC_STAGES-1:0] r_kc_sync;
    logic [SYNC_STAGES-1:0] r_kd_sync;
    logic                   r_kc_prev;
    logic                   w_kc;
    logic                   w_kd;
    logic                   w_edge;

    // frame FSM
    logic [1:0]    r_state;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_par;
    logic [CW-1:0] r_to_cnt;
    logic          w_timeout;

    // sequence assembly
    logic [BW-1:0] r_seq;
    logic [3:0]    r_len;
    logic [BW-1:0] w_seq_new;
    logic [3:0]    w_len_new;
    logic [23:0]   w_lo;
    logic          w_stop_edge;
    logic          w_stop_bad;
    logic          w_par_bad;
    logic          w_good;
    logic          w_match;
    logic          w_complete;

    // error flags
    logic r_parity_err;
    logic r_frame_err;
    logic r_overflow;

    // FIFO
    logic [BW-1:0] r_mem_code [FIFO_DEPTH];
    logic [3:0]    r_mem_len  [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [AW:0]   w_count_next;
    logic          r_empty;
    logic          r_full;
    logic          w_pop;
    logic          w_wr;

    assign w_kc   = r_kc_sync[SYNC_STAGES-1];
    assign w_kd   = r_kd_sync[SYNC_STAGES-1];
    assign w_edge = r_kc_prev & ~w_kc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_kc_sync <= '1;
            r_kd_sync <= '1;
            r_kc_prev <= 1'b1;
        end else begin
            r_kc_sync <= {r_kc_sync[SYNC_STAGES-2:0], key_clock};
            r_kd_sync <= {r_kd_sync[SYNC_STAGES-2:0], key_data};
            r_kc_prev <= w_kc;
        end
    end

    assign w_timeout   = (r_state != ST_IDLE) && !w_edge && (r_to_cnt == TO_LAST);
    assign w_stop_edge = w_edge && (r_state == ST_STOP);
    assign w_stop_bad  = ~w_kd;
    assign w_par_bad   = ~(^{r_shift, r_par});
    assign w_good      = w_stop_edge & ~w_stop_bad & ~w_par_bad;

    // r_to_cnt holds the number of cycles since the last edge, so the abort
    // fires TIMEOUT_CYCLES cycles after that edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par        <= 1'b0;
            r_to_cnt     <= '0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            if (r_state != ST_IDLE) begin
                r_to_cnt <= w_edge ? CW'(1) : r_to_cnt + CW'(1);
            end
            if (w_timeout) begin
                r_state     <= ST_IDLE;
                r_frame_err <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_edge && !w_kd) begin
                            r_state   <= ST_DATA;
                            r_bit_cnt <= '0;
                            r_to_cnt  <= CW'(1);
                        end
                    end
                    ST_DATA: begin
                        if (w_edge) begin
                            r_shift   <= {w_kd, r_shift[7:1]};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_state <= ST_PARITY;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (w_edge) begin
                            r_par   <= w_kd;
                            r_state <= ST_STOP;
                        end
                    end
                    default: begin
                        if (w_edge) begin
                            r_state <= ST_IDLE;
                            if (w_stop_bad) begin
                                r_frame_err <= 1'b1;
                            end else if (w_par_bad) begin
                                r_parity_err <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign w_seq_new = (r_seq << 8) | BW'(r_shift);
    assign w_len_new = r_len + 4'd1;

    always_comb begin
        w_lo = '0;
        for (int unsigned i = 0; i < LB; i++) begin
            w_lo[8*i +: 8] = w_seq_new[8*i +: 8];
        end
    end

    assign w_match = (w_lo[7:0]  == 8'hE0)     || (w_lo[7:0]  == 8'hF0)     ||
                     (w_lo[7:0]  == 8'hE1)     ||
                     (w_lo[15:0] == 16'hE012)  || (w_lo[15:0] == 16'hE114)  ||
                     (w_lo       == 24'hE0F07C) || (w_lo      == 24'hE11477) ||
                     (w_lo       == 24'hE1F014);

    assign w_complete = w_good && (!w_match || (w_len_new == MAX_LEN));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seq <= '0;
            r_len <= '0;
        end else if (w_stop_edge && (w_stop_bad || w_par_bad)) begin
            r_seq <= '0;
            r_len <= '0;
        end else if (w_good) begin
            if (w_complete) begin
                r_seq <= '0;
                r_len <= '0;
            end else begin
                r_seq <= w_seq_new;
                r_len <= w_len_new;
            end
        end
    end

    // a push into a full FIFO still lands if the head is popped that same cycle
    assign w_pop = bus.rd_en & ~r_empty;
    assign w_wr  = w_complete & (~r_full | w_pop);

    always_comb begin
        w_count_next = r_count;
        if (w_wr && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_wr && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem_code[r_wptr] <= w_seq_new;
            r_mem_len[r_wptr]  <= w_len_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_complete && r_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            r_count <= w_count_next;
            r_empty <= (w_count_next == '0);
            r_full  <= (w_count_next == FULL_CNT);
        end
    end

    assign bus.code_out   = r_empty ? '0 : r_mem_code[r_rptr];
    assign bus.code_len   = r_empty ? '0 : r_mem_len[r_rptr];
    assign bus.empty      = r_empty;
    assign bus.full       = r_full;
    assign bus.parity_err = r_parity_err;
    assign bus.frame_err  = r_frame_err;
    assign bus.overflow   = r_overflow;
endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- Parametrised, clk-synchronous PS/2 keyboard receiver; successor to the single-code PS/2 decoder.
- Oversamples key_clock/key_data in the system clock domain and frames 11-bit PS/2 packets with parity, stop and timeout checking.
- Assembles multi-byte scan-code sequences (E0/F0/E1 prefixes) and queues completed codes in a show-ahead FIFO for the consuming logic.

Parameters:
- CODE_BYTES, 4, maximum bytes per assembled code; code_out width is 8*CODE_BYTES.
- FIFO_DEPTH, 4, number of completed codes buffered (power of two, >=2).
- TIMEOUT_CYCLES, 5000, clk cycles without a key_clock falling edge before a partial frame is abandoned.
- SYNC_STAGES, 2, synchroniser flops on key_clock and key_data (>=2).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous reset, active-high.
- key_clock, input, 1, PS/2 clock (asynchronous).
- key_data, input, 1, PS/2 data (asynchronous).
- rd_en, input, 1, pop FIFO head; ignored when empty.
- code_out, output, 8*CODE_BYTES, FIFO head, right-aligned, last received byte in [7:0].
- code_len, output, 4, byte count of the head code (1..CODE_BYTES); 0 when empty.
- empty, output, 1, FIFO empty.
- full, output, 1, FIFO full.
- parity_err, output, 1, one-cycle pulse on bad parity.
- frame_err, output, 1, one-cycle pulse on bad stop bit or timeout.
- overflow, output, 1, sticky; a completed code was dropped because the FIFO was full.

Behaviour:
- Reset (rst high at a clk edge): frame FSM IDLE, sequence buffer cleared, FIFO emptied, empty=1, full=0, code_out=0, code_len=0, all error outputs 0. Reset mid-frame discards everything.
- Sampling: key_clock and key_data pass through SYNC_STAGES flops. An edge cycle is a cycle in which the synchronised key_clock goes 1->0. key_data is sampled only in edge cycles.
- Frame FSM:
  - IDLE: edge with data=0 goes to DATA (bit index 0); edge with data=1 is ignored.
  - DATA: shift bits in LSB first; after the 8th bit, go to PARITY.
  - PARITY: store the parity bit; go to STOP.
  - STOP: require data=1 and an odd count of ones over data+parity. Then return to IDLE.
- Error handling:
  - Parity bad: parity_err pulses in the cycle after the STOP edge; the byte and the partial sequence are discarded.
  - Stop bit 0: frame_err pulses; same discard. If both checks fail, only frame_err pulses.
  - Timeout: in any non-IDLE state, a counter reloads on each edge. At TIMEOUT_CYCLES without an edge, go to IDLE, pulse frame_err and discard the frame; the sequence buffer is kept.
- Sequence assembly: each good byte is shifted into the sequence buffer (buffer <<8 | byte), and len increments.
  - The sequence continues if the buffer's low bytes now match any of: xxE0, xxF0, xxE1, E012, E114, E0F07C, E11477, E1F014.
  - Otherwise it is complete.
  - It is also forced complete when len==CODE_BYTES.
  - On completion, {buffer,len} is pushed and the buffer is cleared.
- FIFO: show-ahead.
  - A push becomes visible on code_out/code_len the cycle after the STOP edge cycle, so empty falls 1 cycle after that edge.
  - rd_en pops in the same cycle; the next entry appears next cycle.
  - A push while full with no pop: the code is dropped and overflow is set until rst.
  - A push and pop in the same cycle while full: both happen, and the count is unchanged.
  - A pop while empty: no effect.
  - full and empty are registered and exact.

Test Plan:
- 'A' press: frame bits 0,00111000,0,1 (data 0x1C, parity 0) -> one cycle after the stop edge: empty=0, code_out=0x1C, code_len=1; rd_en -> empty=1.
- Release sequence F0 (parity 1) then 1C -> single entry code_out=0xF01C, code_len=2, with no entry after the F0 byte alone.
- Up-arrow release E0, F0, 75 -> code_out=0xE0F075, code_len=3; E0 12 E0 7C -> with CODE_BYTES=4: 0xE012E07C, len 4 (forced completion).
- Bad parity on 0x1C (parity bit 1) -> parity_err pulse, no push; a following good 0x1C pushes 0x1C with len 1. Stop bit 0 -> frame_err pulse, no push.
- Stop toggling key_clock after 4 data bits -> frame_err exactly TIMEOUT_CYCLES after the last edge, FSM back in IDLE; next full frame 0x1C is received correctly.
- Send FIFO_DEPTH+1 codes without reading -> full=1 after FIFO_DEPTH, overflow=1 after the extra code, and the FIFO holds the first FIFO_DEPTH codes in order. Assert rst mid-frame -> all outputs return to reset values the next cycle.
